// File: rtl/obuf_ctl_pkg.sv
// Shared constants, types and helpers for the Tx output-buffer strength sequencer.
package obuf_ctl_pkg;

  localparam int NSEG   = 40;
  localparam int CODE_W = 6;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [NSEG-1:0]   therm_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } obuf_seq_state_t;

  // Thermometer: bit i is set when i < code.
  function automatic therm_t therm(input code_t code);
    therm_t t;
    for (int i = 0; i < NSEG; i++) begin
      t[i] = (i < int'(code));
    end
    return t;
  endfunction

  function automatic logic code_over(input code_t code);
    return code > code_t'(NSEG);
  endfunction

  function automatic code_t sat_code(input code_t code);
    return code_over(code) ? code_t'(NSEG) : code;
  endfunction

  // One segment toward tgt; callers only use it when cur != tgt.
  function automatic code_t step_toward(input code_t cur, input code_t tgt);
    return (cur < tgt) ? cur + code_t'(1) : cur - code_t'(1);
  endfunction

endpackage

// File: rtl/obuf_step_timer.sv
// Ramp/settle prescaler: counts 0..STEP_DIV-1 while enabled, tc marks the terminal count.
module obuf_step_timer #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/obuf_ctl_sequencer.sv
// Ramps the N/P driver thermometer enables one segment per step toward loaded targets.
// Optional build macro OBUF_SEQ_ALTERNATE_EN: at most one side steps per tick, N and P alternating.
module obuf_ctl_sequencer
  import obuf_ctl_pkg::*;
#(
  parameter int STEP_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] tgt_n,
  input  logic [CODE_W-1:0] tgt_p,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              sat_err,
  output logic [CODE_W-1:0] cur_n,
  output logic [CODE_W-1:0] cur_p,
  output logic [NSEG-1:0]   ctl_n,
  output logic [NSEG-1:0]   ctl_p
);

  obuf_seq_state_t state;
  code_t           tn, tp;

  code_t eff_n, eff_p;
  code_t cur_n_nxt, cur_p_nxt;
  logic  need_n, need_p;
  logic  step_tick, step_n, step_p;
  logic  arrived;
  logic  tick, timer_clr, timer_en;

`ifdef OBUF_SEQ_ALTERNATE_EN
  logic turn_p;
  logic turn_eff;
`endif

  assign timer_en = (state != IDLE);

  obuf_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc   (tick)
  );

  // A load in the same cycle retargets immediately, so steps and the arrival test use the new codes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
    eff_n     = load ? sat_code(tgt_n) : tn;
    eff_p     = load ? sat_code(tgt_p) : tp;
    need_n    = (cur_n != eff_n);
    need_p    = (cur_p != eff_p);
    step_tick = (state == RAMP) && tick;
`ifdef OBUF_SEQ_ALTERNATE_EN
    turn_eff  = load ? 1'b0 : turn_p;
    step_n    = step_tick && need_n && (!need_p || !turn_eff);
    step_p    = step_tick && need_p && (!need_n || turn_eff);
`else
    step_n    = step_tick && need_n;
    step_p    = step_tick && need_p;
`endif
    cur_n_nxt = step_n ? step_toward(cur_n, eff_n) : cur_n;
    cur_p_nxt = step_p ? step_toward(cur_p, eff_p) : cur_p;
    arrived   = (cur_n_nxt == eff_n) && (cur_p_nxt == eff_p);
    timer_clr = (load && (state != RAMP)) || ((state == RAMP) && arrived);
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      tn      <= '0;
      tp      <= '0;
      cur_n   <= '0;
      cur_p   <= '0;
      ctl_n   <= '0;
      ctl_p   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sat_err <= 1'b0;
`ifdef OBUF_SEQ_ALTERNATE_EN
      turn_p  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (load) begin
        tn <= eff_n;
        tp <= eff_p;
        if (code_over(tgt_n) || code_over(tgt_p)) begin
          sat_err <= 1'b1;
        end
      end

      cur_n <= cur_n_nxt;
      cur_p <= cur_p_nxt;
      ctl_n <= therm(cur_n_nxt);
      ctl_p <= therm(cur_p_nxt);

`ifdef OBUF_SEQ_ALTERNATE_EN
      if (step_tick && need_n && need_p) begin
        turn_p <= ~turn_eff;
      end else if (load) begin
        turn_p <= 1'b0;
      end
`endif

      unique case (state)
        IDLE, SETTLE: begin
          if (load) begin
            // A load restarts from scratch; a settle-done still pending is dropped.
            if (arrived) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end else if ((state == SETTLE) && tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        RAMP: begin
          if (arrived) begin
            state <= SETTLE;
          end
          busy <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obuf_ctl_sequencer.sv
// Self-checking bench for obuf_ctl_sequencer (STEP_DIV=4) against a cycle-level behavioural model.
module tb_obuf_ctl_sequencer;
  import obuf_ctl_pkg::*;

  localparam int SD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic [CODE_W-1:0] tgt_n = '0;
  logic [CODE_W-1:0] tgt_p = '0;
  logic              busy, done, sat_err;
  logic [CODE_W-1:0] cur_n, cur_p;
  logic [NSEG-1:0]   ctl_n, ctl_p;

  obuf_ctl_sequencer #(.STEP_DIV(SD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tgt_n  (tgt_n),
    .tgt_p  (tgt_p),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .sat_err(sat_err),
    .cur_n  (cur_n),
    .cur_p  (cur_p),
    .ctl_n  (ctl_n),
    .ctl_p  (ctl_p)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  int m_n, m_p, m_tn, m_tp, m_phase;
  bit m_ramp, m_settle, m_done, m_sat, m_turn;
  bit nn, np;

  function automatic int sat(input int c);
    return (c > NSEG) ? NSEG : c;
  endfunction

  function automatic int move(input int c, input int t);
    return (c < t) ? c + 1 : c - 1;
  endfunction

  function automatic logic [NSEG-1:0] therm_m(input int n);
    logic [63:0] x;
    x = (64'd1 << n) - 64'd1;
    return x[NSEG-1:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_p = 0; m_tn = 0; m_tp = 0; m_phase = 0;
      m_ramp = 0; m_settle = 0; m_done = 0; m_sat = 0; m_turn = 0;
    end else begin
      m_done = 0;
      if (load) begin
        m_tn = sat(int'(tgt_n));
        m_tp = sat(int'(tgt_p));
        if (tgt_n > NSEG || tgt_p > NSEG) m_sat = 1;
        m_turn = 0;
      end
      if (m_ramp) begin
        m_phase++;
        if (m_phase == SD) begin
          m_phase = 0;
          nn = (m_n != m_tn);
          np = (m_p != m_tp);
`ifdef OBUF_SEQ_ALTERNATE_EN
          if (nn && np) begin
            if (!m_turn) m_n = move(m_n, m_tn);
            else         m_p = move(m_p, m_tp);
            m_turn = !m_turn;
          end else if (nn) begin
            m_n = move(m_n, m_tn);
          end else if (np) begin
            m_p = move(m_p, m_tp);
          end
`else
          if (nn) m_n = move(m_n, m_tn);
          if (np) m_p = move(m_p, m_tp);
`endif
        end
        if (m_n == m_tn && m_p == m_tp) begin
          m_ramp = 0; m_settle = 1; m_phase = 0;
        end
      end else if (load) begin
        if (m_n == m_tn && m_p == m_tp) begin
          m_settle = 0; m_done = 1;
        end else begin
          m_ramp = 1; m_settle = 0; m_phase = 0;
        end
      end else if (m_settle) begin
        m_phase++;
        if (m_phase == SD) begin
          m_settle = 0; m_done = 1;
        end
      end
    end
  end

  function automatic logic [94:0] exp_vec();
    logic b;
    b = m_ramp || m_settle;
    return {b, logic'(m_done), logic'(m_sat), 6'(m_n), 6'(m_p), therm_m(m_n), therm_m(m_p)};
  endfunction

  function automatic logic [94:0] got_vec();
    return {busy, done, sat_err, cur_n, cur_p, ctl_n, ctl_p};
  endfunction

  // ---------------- one-bit-change monitor ----------------
  logic            rst_at_edge = 1'b0;
  logic [NSEG-1:0] prev_n = '0, prev_p = '0;

  always @(posedge clk) rst_at_edge = rst_n;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      vectors++;
      if ($countones(ctl_n ^ prev_n) > 1 || $countones(ctl_p ^ prev_p) > 1) begin
        miscompares++;
        $display("FAIL glitch: ctl_n %h->%h ctl_p %h->%h, need <=1 bit change", prev_n, ctl_n, prev_p, ctl_p);
      end
    end
    prev_n = ctl_n;
    prev_p = ctl_p;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load(input int n, input int p);
    load  = 1'b1;
    tgt_n = 6'(n);
    tgt_p = 6'(p);
    adv();
    load  = 1'b0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; tgt_n = 6'd40; tgt_p = 6'd40;
    repeat (3) adv();
    vectors++;
    if (got_vec() !== 95'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want 0", got_vec());
    end
    rst_n = 1'b1; load = 1'b0; tgt_n = '0; tgt_p = '0;
    adv();
    vectors++;
    if (busy !== 1'b0 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_up_ramp();
    int t = 0, t_arr = -1, t_done = -1;
    pulse_load(5, 3);
    for (int c = 0; c < 80 && t_done < 0; c++) begin
      if (c > 0) adv();
      t++;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL up_ramp c%0d: got %h want %h", c, got_vec(), exp_vec());
      end
      if (cur_n == 6'd5 && t_arr < 0) t_arr = t;
      if (done) t_done = t;
    end
    vectors++;
    if (t_done - t_arr != SD) begin
      miscompares++;
      $display("FAIL up_ramp_done_lag: got %0d want %0d", t_done - t_arr, SD);
    end
    vectors++;
    if (ctl_n !== 40'h1F || ctl_p !== 40'h07) begin
      miscompares++;
      $display("FAIL up_ramp_ctl: got n=%h p=%h want n=1f p=07", ctl_n, ctl_p);
    end
  endtask

  task automatic test_saturation();
    hard_reset();
    pulse_load(63, 0);
    for (int c = 0; c < 250 && !done; c++) begin
      adv();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sat_ramp c%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (sat_err !== 1'b1 || cur_n !== 6'd40 || ctl_n !== {NSEG{1'b1}}) begin
      miscompares++;
      $display("FAIL sat_end: got sat=%b n=%0d ctl=%h want 1/40/all-ones", sat_err, cur_n, ctl_n);
    end
    pulse_load(10, 0);
    for (int c = 0; c < 250 && !done; c++) adv();
    vectors++;
    if (sat_err !== 1'b1 || cur_n !== 6'd10) begin
      miscompares++;
      $display("FAIL sat_sticky: got sat=%b n=%0d want 1/10", sat_err, cur_n);
    end
  endtask

  task automatic test_retarget();
    int max_n = 0, dones = 0;
    bit hit = 0;
    hard_reset();
    pulse_load(20, 0);
    for (int c = 0; c < 100 && !hit; c++) begin
      adv();
      if (cur_n == 6'd8) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL retarget_wait: got timeout want cur_n=8");
    end
    pulse_load(2, 0);
    for (int c = 0; c < 120; c++) begin
      adv();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL retarget c%0d: got %h want %h", c, got_vec(), exp_vec());
      end
      if (int'(cur_n) > max_n) max_n = int'(cur_n);
      if (done) dones++;
    end
    vectors++;
    if (max_n >= 20 || dones != 1 || cur_n !== 6'd2) begin
      miscompares++;
      $display("FAIL retarget_end: got max=%0d dones=%0d n=%0d want <20/1/2", max_n, dones, cur_n);
    end
  endtask

  task automatic test_noop_load();
    pulse_load(int'(cur_n), int'(cur_p));
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL noop_load: got busy=%b done=%b want 0/1", busy, done);
    end
    adv();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL noop_after: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 0;
    pulse_load(20, 9);
    for (int c = 0; c < 100 && !hit; c++) begin
      adv();
      if (cur_n == 6'd7) hit = 1;
    end
    rst_n = 1'b0;
    adv();
    vectors++;
    if (!hit || got_vec() !== 95'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got hit=%b vec=%h want 1/0", hit, got_vec());
    end
    rst_n = 1'b1;
    repeat (SD + 2) adv();
    vectors++;
    if (got_vec() !== 95'd0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: got %h want 0", got_vec());
    end
  endtask

  task automatic test_step_order();
    string order = "";
    string want;
    logic [CODE_W-1:0] pn = '0, pp = '0;
`ifdef OBUF_SEQ_ALTERNATE_EN
    want = "NPNP";
`else
    want = "BB";
`endif
    hard_reset();
    pulse_load(2, 2);
    for (int c = 0; c < 60 && !done; c++) begin
      if (cur_n != pn && cur_p != pp) order = {order, "B"};
      else if (cur_n != pn) order = {order, "N"};
      else if (cur_p != pp) order = {order, "P"};
      pn = cur_n; pp = cur_p;
      adv();
    end
    vectors++;
    if (order != want) begin
      miscompares++;
      $display("FAIL step_order: got %s want %s", order, want);
    end
  endtask

  task automatic test_random();
    int w;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
      end
      tgt_n = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
      tgt_p = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
      w = $urandom_range(1, 45);
      for (int c = 0; c < w; c++) begin
        load = (c == 0);
        adv();
        vectors++;
        if (got_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL random it%0d c%0d: got %h want %h", it, c, got_vec(), exp_vec());
        end
      end
      load = 1'b0;
    end
    for (int c = 0; c < 400 && busy; c++) begin
      adv();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_drain c%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_saturation();
    test_retarget();
    test_noop_load();
    test_mid_reset();
    test_step_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
